isqrt_share_arbiter: RTL and testbench

Shares one pipelined isqrt unit among N_REQ formula FSMs. Each requester keeps its own isqrt-style pulse interface (x_vld/x out, y_vld/y back). The arbiter buffers one pending argument per requester, issues arguments to the shared unit round-robin, and routes each result back to its originator through an in-order tag FIFO. It sits between the formula FSMs and a single isqrt instance.

---
 rtl/isqrt_share_arbiter.sv | 121 ++++++++++++
 tb/tb_isqrt_share_arbiter.sv | 532 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/isqrt_share_arbiter.sv
// isqrt_share_arbiter: shares one pipelined isqrt among N_REQ requesters.
// Round-robin issue from per-requester slots; results routed by tag FIFO.
module isqrt_share_arbiter #(
  parameter int N_REQ   = 3,
  parameter int MAX_OUT = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_x_vld,
  input  logic [N_REQ*32-1:0]      req_x,
  output logic [N_REQ-1:0]         req_busy,
  output logic [N_REQ-1:0]         req_y_vld,
  output logic [15:0]              req_y,
  output logic                     isqrt_x_vld,
  output logic [31:0]              isqrt_x,
  input  logic                     isqrt_y_vld,
  input  logic [15:0]              isqrt_y,
  output logic [$clog2(MAX_OUT):0] outstanding,
  output logic                     ovf_err,
  output logic                     spur_err
);

  localparam int PW = $clog2(MAX_OUT);
  localparam int TW = $clog2(N_REQ);

  logic [N_REQ-1:0] r_vld;
  logic [31:0]      r_dat [N_REQ];
  logic [TW-1:0]    r_last;
  logic [TW-1:0]    r_tag [MAX_OUT];
  logic [PW-1:0]    r_wp;
  logic [PW-1:0]    r_rp;
  logic [PW:0]      r_cnt;

  logic             w_gnt;
  logic [TW-1:0]    w_gidx;
  logic [N_REQ-1:0] w_goh;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;

  assign w_full      = (r_cnt == (PW+1)'(MAX_OUT));
  assign w_empty     = (r_cnt == '0);
  assign w_pop       = isqrt_y_vld && !w_empty;
  assign req_busy    = r_vld;
  assign outstanding = r_cnt;

  // Search starts one past the last winner; the count is pre-pop.
  always_comb begin : p_gnt
    int            s;
    logic [TW-1:0] idx;
    s      = 0;
    idx    = '0;
    w_gnt  = 1'b0;
    w_gidx = '0;
    w_goh  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      s   = (int'(r_last) + k) % N_REQ;
      idx = TW'(s);
      if (!w_gnt && !w_full && r_vld[idx]) begin
        w_gnt  = 1'b1;
        w_gidx = idx;
      end
    end
    if (w_gnt) w_goh = N_REQ'(1) << w_gidx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      for (int i = 0; i < N_REQ; i++) r_dat[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (req_x_vld[i] && (!r_vld[i] || w_goh[i])) begin
          r_vld[i] <= 1'b1;
          r_dat[i] <= req_x[32*i +: 32];
        end else if (w_goh[i]) begin
          r_vld[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      isqrt_x_vld <= 1'b0;
      isqrt_x     <= '0;
      r_last      <= TW'(N_REQ-1);
      r_wp        <= '0;
      r_rp        <= '0;
      r_cnt       <= '0;
      req_y_vld   <= '0;
      req_y       <= '0;
      ovf_err     <= 1'b0;
      spur_err    <= 1'b0;
      for (int i = 0; i < MAX_OUT; i++) r_tag[i] <= '0;
    end else begin
      isqrt_x_vld <= w_gnt;
      ovf_err     <= |(req_x_vld & r_vld & ~w_goh);
      spur_err    <= isqrt_y_vld && w_empty;
      if (w_gnt) begin
        isqrt_x     <= r_dat[w_gidx];
        r_tag[r_wp] <= w_gidx;
        r_wp        <= r_wp + 1'b1;
        r_last      <= w_gidx;
      end
      if (w_pop) begin
        r_rp      <= r_rp + 1'b1;
        req_y     <= isqrt_y;
        req_y_vld <= N_REQ'(1) << r_tag[r_rp];
      end else begin
        req_y_vld <= '0;
      end
      unique case ({w_gnt, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_isqrt_share_arbiter.sv
// tb_isqrt_share_arbiter: directed checks of the shared isqrt arbiter.
// Uses a 4-cycle isqrt model with a manual (stalled) override.
module tb_isqrt_share_arbiter;

  localparam int N = 3;
  localparam int M = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req_x_vld = '0;
  logic [N*32-1:0] req_x = '0;
  logic [N-1:0]  req_busy;
  logic [N-1:0]  req_y_vld;
  logic [15:0]   req_y;
  logic          isqrt_x_vld;
  logic [31:0]   isqrt_x;
  logic          isqrt_y_vld;
  logic [15:0]   isqrt_y;
  logic [2:0]    outstanding;
  logic          ovf_err;
  logic          spur_err;

  int errors = 0;
  int checks = 0;

  logic        manual = 1'b0;
  logic        m_vld = 1'b0;
  logic [15:0] m_y = '0;
  logic [2:0]  s_v;
  logic [15:0] s_y [3];
  logic        p_vld;
  logic [15:0] p_y;

  isqrt_share_arbiter #(.N_REQ(N), .MAX_OUT(M)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_x_vld(req_x_vld), .req_x(req_x),
    .req_busy(req_busy), .req_y_vld(req_y_vld), .req_y(req_y),
    .isqrt_x_vld(isqrt_x_vld), .isqrt_x(isqrt_x),
    .isqrt_y_vld(isqrt_y_vld), .isqrt_y(isqrt_y),
    .outstanding(outstanding),
    .ovf_err(ovf_err), .spur_err(spur_err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] fsqrt(input logic [31:0] x);
    longint r;
    r = 0;
    while ((r + 1) * (r + 1) <= longint'(x)) r++;
    return r[15:0];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_v <= '0;
      for (int i = 0; i < 3; i++) s_y[i] <= '0;
      p_vld <= 1'b0;
      p_y <= '0;
    end else begin
      s_v[0] <= isqrt_x_vld;
      s_y[0] <= fsqrt(isqrt_x);
      s_v[1] <= s_v[0];
      s_y[1] <= s_y[0];
      s_v[2] <= s_v[1];
      s_y[2] <= s_y[1];
      p_vld <= s_v[2];
      p_y <= s_y[2];
    end
  end

  assign isqrt_y_vld = manual ? m_vld : p_vld;
  assign isqrt_y     = manual ? m_y : p_y;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle();
    req_x_vld = '0;
    req_x = '0;
    m_vld = 1'b0;
    m_y = '0;
  endtask

  task automatic put(input int r, input logic [31:0] x);
    req_x_vld[r] = 1'b1;
    req_x[32*r +: 32] = x;
  endtask

  task automatic do_reset();
    idle();
    manual = 1'b0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    logic [59:0] v;
    idle();
    rst_n = 1'b0;
    repeat (3) step();
    v = {req_busy, req_y_vld, req_y, isqrt_x_vld, isqrt_x,
         outstanding, ovf_err, spur_err};
    if (v !== '0) begin
      errors++;
      $display("FAIL reset_outputs got=%h want=0", v);
    end
    checks++;
    rst_n = 1'b1;
    step();
    v = {req_busy, req_y_vld, req_y, isqrt_x_vld, isqrt_x,
         outstanding, ovf_err, spur_err};
    if (v !== '0) begin
      errors++;
      $display("FAIL post_reset_idle got=%h want=0", v);
    end
    checks++;
  endtask

  task automatic test_single();
    logic [2:0] ey;
    do_reset();
    put(1, 32'd144);
    for (int c = 1; c <= 8; c++) begin
      step();
      idle();
      if (c == 1) begin
        if (req_busy !== 3'b010) begin
          errors++;
          $display("FAIL single_busy got=%b want=010", req_busy);
        end
        checks++;
      end
      if (isqrt_x_vld !== (c == 2)) begin
        errors++;
        $display("FAIL single_xvld c=%0d got=%b want=%b",
                 c, isqrt_x_vld, (c == 2));
      end
      checks++;
      if (c == 2) begin
        if (isqrt_x !== 32'd144) begin
          errors++;
          $display("FAIL single_x got=%0d want=144", isqrt_x);
        end
        checks++;
      end
      ey = (c == 7) ? 3'b010 : 3'b000;
      if (req_y_vld !== ey) begin
        errors++;
        $display("FAIL single_yvld c=%0d got=%b want=%b", c, req_y_vld, ey);
      end
      checks++;
      if (c == 7) begin
        if (req_y !== 16'd12) begin
          errors++;
          $display("FAIL single_y got=%0d want=12", req_y);
        end
        checks++;
      end
      if ({ovf_err, spur_err} !== 2'b00) begin
        errors++;
        $display("FAIL single_err c=%0d got=%b want=00", c, {ovf_err, spur_err});
      end
      checks++;
    end
  endtask

  task automatic test_round_robin();
    logic [2:0]  ey;
    logic [15:0] yv;
    do_reset();
    for (int b = 0; b < 2; b++) begin
      for (int r = 0; r < 3; r++) begin
        yv = 16'(2 + 3*b + r);
        put(r, 32'(yv) * 32'(yv));
      end
      for (int c = 1; c <= 10; c++) begin
        step();
        idle();
        if (isqrt_x_vld !== (c >= 2 && c <= 4)) begin
          errors++;
          $display("FAIL rr_xvld b=%0d c=%0d got=%b", b, c, isqrt_x_vld);
        end
        checks++;
        if (c >= 2 && c <= 4) begin
          yv = 16'(2 + 3*b + c - 2);
          if (isqrt_x !== 32'(yv) * 32'(yv)) begin
            errors++;
            $display("FAIL rr_x b=%0d c=%0d got=%0d want=%0d",
                     b, c, isqrt_x, 32'(yv) * 32'(yv));
          end
          checks++;
        end
        if (c == 5) begin
          if (outstanding !== 3'd3) begin
            errors++;
            $display("FAIL rr_outstanding got=%0d want=3", outstanding);
          end
          checks++;
        end
        ey = (c >= 7 && c <= 9) ? 3'(1 << (c - 7)) : 3'b000;
        if (req_y_vld !== ey) begin
          errors++;
          $display("FAIL rr_yvld b=%0d c=%0d got=%b want=%b", b, c, req_y_vld, ey);
        end
        checks++;
        if (c >= 7 && c <= 9) begin
          yv = 16'(2 + 3*b + c - 7);
          if (req_y !== yv) begin
            errors++;
            $display("FAIL rr_y b=%0d c=%0d got=%0d want=%0d", b, c, req_y, yv);
          end
          checks++;
        end
      end
    end
  endtask

  task automatic test_overflow();
    logic [2:0]  eb;
    logic [2:0]  ey;
    logic [31:0] ex;
    logic [15:0] eyv;
    do_reset();
    put(1, 32'd100);
    for (int c = 1; c <= 8; c++) begin
      step();
      idle();
      if (c == 7) begin
        if ({req_y_vld, req_y} !== {3'b010, 16'd10}) begin
          errors++;
          $display("FAIL ovf_pre got=%b/%0d want=010/10", req_y_vld, req_y);
        end
        checks++;
      end
    end
    put(2, 32'd49);
    put(0, 32'd1);
    for (int d = 1; d <= 10; d++) begin
      step();
      idle();
      if (d == 1) put(0, 32'd4);
      if (d == 2) put(0, 32'd9);
      case (d)
        1: eb = 3'b101;
        2: eb = 3'b001;
        3: eb = 3'b001;
        default: eb = 3'b000;
      endcase
      if (req_busy !== eb) begin
        errors++;
        $display("FAIL ovf_busy d=%0d got=%b want=%b", d, req_busy, eb);
      end
      checks++;
      if (ovf_err !== (d == 2)) begin
        errors++;
        $display("FAIL ovf_err d=%0d got=%b want=%b", d, ovf_err, (d == 2));
      end
      checks++;
      case (d)
        2: ex = 32'd49;
        3: ex = 32'd1;
        4: ex = 32'd9;
        default: ex = 32'd0;
      endcase
      if (isqrt_x_vld !== (d >= 2 && d <= 4)) begin
        errors++;
        $display("FAIL ovf_xvld d=%0d got=%b", d, isqrt_x_vld);
      end
      checks++;
      if (d >= 2 && d <= 4) begin
        if (isqrt_x !== ex) begin
          errors++;
          $display("FAIL ovf_x d=%0d got=%0d want=%0d", d, isqrt_x, ex);
        end
        checks++;
      end
      case (d)
        7: begin ey = 3'b100; eyv = 16'd7; end
        8: begin ey = 3'b001; eyv = 16'd1; end
        9: begin ey = 3'b001; eyv = 16'd3; end
        default: begin ey = 3'b000; eyv = 16'd0; end
      endcase
      if (req_y_vld !== ey) begin
        errors++;
        $display("FAIL ovf_yvld d=%0d got=%b want=%b", d, req_y_vld, ey);
      end
      checks++;
      if (ey != 3'b000) begin
        if (req_y !== eyv) begin
          errors++;
          $display("FAIL ovf_y d=%0d got=%0d want=%0d", d, req_y, eyv);
        end
        checks++;
      end
    end
  endtask

  task automatic test_fifo_full();
    logic        exv;
    logic [31:0] ex;
    logic [2:0]  ey;
    logic [15:0] eyv;
    do_reset();
    manual = 1'b1;
    put(0, 32'd4);
    put(1, 32'd9);
    put(2, 32'd16);
    for (int c = 1; c <= 17; c++) begin
      step();
      idle();
      case (c)
        1:  put(0, 32'd25);
        2:  put(1, 32'd36);
        9:  begin m_vld = 1'b1; m_y = 16'd2; end
        12: begin m_vld = 1'b1; m_y = 16'd3; end
        13: begin m_vld = 1'b1; m_y = 16'd4; end
        14: begin m_vld = 1'b1; m_y = 16'd5; end
        15: begin m_vld = 1'b1; m_y = 16'd6; end
        default: ;
      endcase
      exv = 1'b1;
      case (c)
        2:  ex = 32'd4;
        3:  ex = 32'd9;
        4:  ex = 32'd16;
        5:  ex = 32'd25;
        11: ex = 32'd36;
        default: begin exv = 1'b0; ex = 32'd0; end
      endcase
      if (isqrt_x_vld !== exv) begin
        errors++;
        $display("FAIL full_xvld c=%0d got=%b want=%b", c, isqrt_x_vld, exv);
      end
      checks++;
      if (exv) begin
        if (isqrt_x !== ex) begin
          errors++;
          $display("FAIL full_x c=%0d got=%0d want=%0d", c, isqrt_x, ex);
        end
        checks++;
      end
      if (c == 8) begin
        if ({outstanding, req_busy} !== {3'd4, 3'b010}) begin
          errors++;
          $display("FAIL full_stall got=%0d/%b want=4/010", outstanding, req_busy);
        end
        checks++;
      end
      case (c)
        10: begin ey = 3'b001; eyv = 16'd2; end
        13: begin ey = 3'b010; eyv = 16'd3; end
        14: begin ey = 3'b100; eyv = 16'd4; end
        15: begin ey = 3'b001; eyv = 16'd5; end
        16: begin ey = 3'b010; eyv = 16'd6; end
        default: begin ey = 3'b000; eyv = 16'd0; end
      endcase
      if (req_y_vld !== ey) begin
        errors++;
        $display("FAIL full_yvld c=%0d got=%b want=%b", c, req_y_vld, ey);
      end
      checks++;
      if (ey != 3'b000) begin
        if (req_y !== eyv) begin
          errors++;
          $display("FAIL full_y c=%0d got=%0d want=%0d", c, req_y, eyv);
        end
        checks++;
      end
    end
    if (outstanding !== 3'd0) begin
      errors++;
      $display("FAIL full_drain got=%0d want=0", outstanding);
    end
    checks++;
    manual = 1'b0;
  endtask

  task automatic test_spur_wrap();
    logic [18:0] q[$];
    logic [18:0] e;
    int sent;
    int got;
    int cyc;
    logic [15:0] yv;
    do_reset();
    manual = 1'b1;
    m_vld = 1'b1;
    m_y = 16'd5;
    step();
    idle();
    if ({spur_err, req_y_vld, outstanding} !== {1'b1, 3'b000, 3'd0}) begin
      errors++;
      $display("FAIL spur_pulse got=%b/%b/%0d want=1/000/0",
               spur_err, req_y_vld, outstanding);
    end
    checks++;
    step();
    if (spur_err !== 1'b0) begin
      errors++;
      $display("FAIL spur_width got=%b want=0", spur_err);
    end
    checks++;
    manual = 1'b0;
    sent = 0;
    got = 0;
    cyc = 0;
    while (got < 40 && cyc < 400) begin
      step();
      cyc++;
      idle();
      if (req_y_vld !== 3'b000) begin
        if (q.size() == 0) begin
          errors++;
          $display("FAIL wrap_extra got=%b want=none", req_y_vld);
          checks++;
        end else begin
          e = q.pop_front();
          if ({req_y_vld, req_y} !== e) begin
            errors++;
            $display("FAIL wrap_route n=%0d got=%b/%0d want=%b/%0d",
                     got, req_y_vld, req_y, e[18:16], e[15:0]);
          end
          checks++;
          got++;
        end
      end
      if (ovf_err !== 1'b0) begin
        errors++;
        $display("FAIL wrap_ovf cyc=%0d got=1 want=0", cyc);
        checks++;
      end
      if (sent < 40 && (cyc % 2) == 0) begin
        yv = 16'(sent + 3);
        put(sent % 3, 32'(yv) * 32'(yv) + 32'(sent % 2));
        q.push_back({3'(1 << (sent % 3)), yv});
        sent++;
      end
    end
    if (got != 40) begin
      errors++;
      $display("FAIL wrap_timeout got=%0d want=40", got);
    end
    checks++;
  endtask

  task automatic test_async_reset();
    logic [59:0] v;
    logic [2:0]  ey;
    do_reset();
    manual = 1'b1;
    put(0, 32'd4);
    put(1, 32'd9);
    put(2, 32'd16);
    for (int c = 1; c <= 6; c++) begin
      step();
      idle();
    end
    if (outstanding !== 3'd3) begin
      errors++;
      $display("FAIL arst_pre got=%0d want=3", outstanding);
    end
    checks++;
    #2;
    rst_n = 1'b0;
    #1;
    v = {req_busy, req_y_vld, req_y, isqrt_x_vld, isqrt_x,
         outstanding, ovf_err, spur_err};
    if (v !== '0) begin
      errors++;
      $display("FAIL arst_outputs got=%h want=0", v);
    end
    checks++;
    step();
    step();
    rst_n = 1'b1;
    manual = 1'b0;
    step();
    put(2, 32'd81);
    for (int c = 1; c <= 8; c++) begin
      step();
      idle();
      if (isqrt_x_vld !== (c == 2)) begin
        errors++;
        $display("FAIL arst_xvld c=%0d got=%b want=%b", c, isqrt_x_vld, (c == 2));
      end
      checks++;
      if (c == 2) begin
        if (isqrt_x !== 32'd81) begin
          errors++;
          $display("FAIL arst_x got=%0d want=81", isqrt_x);
        end
        checks++;
      end
      ey = (c == 7) ? 3'b100 : 3'b000;
      if (req_y_vld !== ey) begin
        errors++;
        $display("FAIL arst_yvld c=%0d got=%b want=%b", c, req_y_vld, ey);
      end
      checks++;
      if (c == 7) begin
        if (req_y !== 16'd9) begin
          errors++;
          $display("FAIL arst_y got=%0d want=9", req_y);
        end
        checks++;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_overflow();
    test_fifo_full();
    test_spur_wrap();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
